// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU.
//   DEFAULT_WIDTH : default datapath width.
//   ALU_*         : 3-bit ALUOp operation encodings.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for operations that run the shared adder in subtract mode.
    function automatic logic op_uses_sub(input logic [2:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational right shifter, logical or arithmetic, built as a log2 barrel
// of conditional power-of-two stages.
// Ports:
//   i_data  [WIDTH-1:0]   : value to shift
//   i_shamt [SHAMT_W-1:0] : shift amount
//   i_arith               : 1 = sign fill from i_data MSB, 0 = zero fill
//   o_data  [WIDTH-1:0]   : shifted result
// -----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_arith,
    output logic [WIDTH-1:0]   o_data
);

    // w_stage[k] is the value after applying shamt bits [k-1:0].
    logic [WIDTH-1:0] w_stage [SHAMT_W+1];
    logic             w_fill;

    assign w_fill     = i_arith & i_data[WIDTH-1];
    assign w_stage[0] = i_data;

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign w_stage[gi+1] = i_shamt[gi]
                ? {{STEP{w_fill}}, w_stage[gi][WIDTH-1:STEP]}
                : w_stage[gi];
        end
    endgenerate

    assign o_data = w_stage[SHAMT_W];

endmodule

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// Execute-stage integer ALU with a registered result (one cycle latency,
// one operation per cycle, no backpressure).
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   A, B       : operands; B[SHAMT_W-1:0] is the shift amount
//   ALUOp      : operation select (see alu_pkg)
//   in_valid   : operands valid this cycle
//   C          : registered result
//   zero       : registered, high when C == 0
//   overflow   : registered signed overflow for ADD/SUB, else 0
//   out_valid  : registered copy of in_valid
// -----------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    input  logic             in_valid,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid
);

    localparam int SHAMT_W = $clog2(WIDTH);

    // ---------------- shared adder / subtractor ----------------
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_into_msb;
    logic             w_add_ovf;
    logic             w_slt;

    assign w_sub     = op_uses_sub(ALUOp);
    assign w_b_eff   = w_sub ? ~B : B;
    assign w_sum_ext = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_sum     = w_sum_ext[WIDTH-1:0];

    // Signed overflow is the carry into the MSB disagreeing with the carry
    // out of it; this is the only use of the carry-out.
    assign w_carry_into_msb = A[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_add_ovf        = w_carry_into_msb ^ w_sum_ext[WIDTH];

    // A < B (signed): the sign of A-B is wrong exactly when it overflowed.
    assign w_slt = w_sum[WIDTH-1] ^ w_add_ovf;

    // ---------------- shifter ----------------
    logic [WIDTH-1:0] w_shift;

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .i_data  (A),
        .i_shamt (B[SHAMT_W-1:0]),
        .i_arith (ALUOp == ALU_SRA),
        .o_data  (w_shift)
    );

    // ---------------- result select ----------------
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        unique case (ALUOp)
            ALU_ADD: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            ALU_SUB: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            ALU_AND: w_result = A & B;
            ALU_OR:  w_result = A | B;
            ALU_SRL: w_result = w_shift;
            ALU_SRA: w_result = w_shift;
            ALU_XOR: w_result = A ^ B;
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: begin
                w_result = '0;
                w_ovf    = 1'b0;
            end
        endcase
    end

    // ---------------- output register ----------------
    logic [WIDTH-1:0] r_c;
    logic             r_zero;
    logic             r_ovf;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c     <= '0;
            r_zero  <= 1'b1;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            // Result and flags hold while no operation is presented.
            if (in_valid) begin
                r_c    <= w_result;
                r_zero <= (w_result == '0);
                r_ovf  <= w_ovf;
            end
        end
    end

    assign C         = r_c;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Directed vectors with hand-computed expectations. Each issued cycle pushes
// the expected register contents (due one cycle later) into a scoreboard; an
// independent monitor compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_unit;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic        in_valid;
    logic [31:0] C;
    logic        zero;
    logic        overflow;
    logic        out_valid;

    alu_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .in_valid  (in_valid),
        .C         (C),
        .zero      (zero),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          due;
        logic [31:0] c;
        logic        z;
        logic        o;
        logic        v;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    // Drive one cycle of stimulus and record the expected register contents.
    task automatic issue(input string nm, input logic rst, input logic vld,
                         input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ec,
                         input logic ez, input logic eo, input logic ev);
        exp_t e;
        @(posedge clk);
        #2;
        reset    = rst;
        in_valid = vld;
        ALUOp    = op;
        A        = a;
        B        = b;
        e.due = cyc + 1;
        e.c   = ec;
        e.z   = ez;
        e.o   = eo;
        e.v   = ev;
        exp_q.push_back(e);
        name_q.push_back(nm);
        $display("issue %-10s rst=%0b vld=%0b op=%0d A=%08h B=%08h -> C=%08h z=%0b o=%0b v=%0b",
                 nm, rst, vld, op, a, b, ec, ez, eo, ev);
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: stale expectation due=%0d now=%0d", nm, e.due, cyc);
                end else begin
                    checks++;
                    if (C !== e.c) begin
                        errors++;
                        $display("FAIL %s C: got %08h want %08h", nm, C, e.c);
                    end
                    checks++;
                    if (zero !== e.z) begin
                        errors++;
                        $display("FAIL %s zero: got %0b want %0b", nm, zero, e.z);
                    end
                    checks++;
                    if (overflow !== e.o) begin
                        errors++;
                        $display("FAIL %s overflow: got %0b want %0b", nm, overflow, e.o);
                    end
                    checks++;
                    if (out_valid !== e.v) begin
                        errors++;
                        $display("FAIL %s out_valid: got %0b want %0b", nm, out_valid, e.v);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        ALUOp    = ALU_ADD;
        A        = 32'd123;
        B        = 32'd456;

        // Reset with live-looking inputs.
        issue("reset0", 1, 1, ALU_ADD, 32'd123, 32'd456, 32'h0, 1, 0, 0);
        issue("reset1", 1, 1, ALU_XOR, 32'hDEADBEEF, 32'h1, 32'h0, 1, 0, 0);

        // Add / sub, back-to-back every cycle.
        issue("add_ovf",  0, 1, ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 1);
        issue("sub_ovf",  0, 1, ALU_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 1);
        issue("sub_zero", 0, 1, ALU_SUB, 32'd5, 32'd5, 32'h0, 1, 0, 1);
        issue("add_small",0, 1, ALU_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 1);
        issue("add_wrap", 0, 1, ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 1);
        issue("add_negov",0, 1, ALU_ADD, 32'h80000000, 32'h80000000, 32'h0, 1, 1, 1);
        issue("sub_neg",  0, 1, ALU_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 1);

        // Logic ops.
        issue("and", 0, 1, ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 1);
        issue("or",  0, 1, ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 1);
        issue("xor", 0, 1, ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 1);

        // Shifts.
        issue("srl4",   0, 1, ALU_SRL, 32'h80000010, 32'd4, 32'h08000001, 0, 0, 1);
        issue("sra4",   0, 1, ALU_SRA, 32'h80000010, 32'd4, 32'hF8000001, 0, 0, 1);
        issue("sra0",   0, 1, ALU_SRA, 32'h80000010, 32'hFFFFFFE0, 32'h80000010, 0, 0, 1);
        issue("srl31",  0, 1, ALU_SRL, 32'h80000000, 32'd31, 32'h00000001, 0, 0, 1);
        issue("sra31",  0, 1, ALU_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 0, 1);
        issue("sra_pos",0, 1, ALU_SRA, 32'h40000000, 32'd30, 32'h00000001, 0, 0, 1);

        // Signed set-less-than, including the overflowing A-B case.
        issue("slt_m1_1",  0, 1, ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 1);
        issue("slt_ovf",   0, 1, ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 0, 1);
        issue("slt_1_m1",  0, 1, ALU_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0, 1);

        // Hold while in_valid is low.
        issue("add_pre",  0, 1, ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 0, 1, 1);
        issue("hold0",    0, 0, ALU_SUB, 32'd5, 32'd5, 32'hFFFFFFFE, 0, 1, 0);
        issue("hold1",    0, 0, ALU_AND, 32'h0, 32'h0, 32'hFFFFFFFE, 0, 1, 0);
        issue("xor_post", 0, 1, ALU_XOR, 32'h1, 32'h3, 32'h2, 0, 0, 1);

        // Reset in the middle of a burst discards that edge's operation.
        issue("burst0",   0, 1, ALU_ADD, 32'd1, 32'd1, 32'd2, 0, 0, 1);
        issue("mid_rst",  1, 1, ALU_ADD, 32'd10, 32'd20, 32'h0, 1, 0, 0);
        issue("burst1",   0, 1, ALU_ADD, 32'd10, 32'd20, 32'd30, 0, 0, 1);

        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
